lzc_norm_ctrl_decomposable: RTL and testbench

//  Pipelined normalisation-control stage upstream of the decomposable left shifter.

---
 rtl/pe_pkg.sv | 37 +++
 rtl/lzc_decomposable.sv | 92 +++++++++
 rtl/lzc_norm_ctrl_decomposable.sv | 157 +++++++++++++++
 tb/tb_lzc_norm_ctrl_decomposable.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared processing-element definitions: precision-mode encodings, lane
// geometry of the 32-bit datapath, and an 8-bit leading-zero count helper
// used by the decomposable LZC.
// ---------------------------------------------------------------------------
package pe_pkg;

  localparam int PRECISION_CONFIG_L = 2;

  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
  localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;

  localparam int LANE_W  = 8;
  localparam int N_LANE  = 4;
  localparam int LZC_W   = 6;
  localparam int SHIFT_W = 5;
  localparam int DATA_W  = LANE_W * N_LANE;

  // Leading-zero count of one 8-bit lane, result 0..8.
  function automatic logic [3:0] lzc8(input logic [LANE_W-1:0] v);
    logic [3:0] cnt;
    logic       found;
    cnt   = 4'd0;
    found = 1'b0;
    for (int i = LANE_W - 1; i >= 0; i--) begin
      if (!found && !v[i]) begin
        cnt = cnt + 4'd1;
      end else begin
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lzc_decomposable.sv
// ---------------------------------------------------------------------------
// lzc_decomposable
// Combinational leading-zero (or leading-one) counter that can be split into
// one 32-bit, two 16-bit or four 8-bit elements.  Lane counts are merged
// pairwise into element counts, then replicated back onto the lanes each
// element owns.
// Ports:
//   data_i  - 32-bit operand, lane i = bits [8i+7:8i]
//   mode_i  - precision mode (unknown encodings behave as 32B)
//   shift_o - per-lane shift amount for the decomposable shifter
//   full_o  - whole 32-bit operand is all-extension (32B only)
//   lzc_o   - per-lane count of the owning element
// ---------------------------------------------------------------------------
module lzc_decomposable
  import pe_pkg::*;
#(
  parameter bit COUNT_LEADING_ONES = 1'b0
) (
  input  logic [DATA_W-1:0]                    data_i,
  input  logic [PRECISION_CONFIG_L-1:0]        mode_i,
  output logic [N_LANE-1:0][SHIFT_W-1:0]       shift_o,
  output logic                                 full_o,
  output logic [N_LANE-1:0][LZC_W-1:0]         lzc_o
);

  logic [DATA_W-1:0]   src_s;
  logic [N_LANE-1:0][3:0] c8_s;
  logic [1:0][4:0]     c16_s;
  logic [5:0]          c32_s;

  // Counting leading ones is the same as counting leading zeros of the inverse.
  assign src_s = COUNT_LEADING_ONES ? ~data_i : data_i;

  // Per-lane 8-bit counts.
  always_comb begin
    for (int i = 0; i < N_LANE; i++) begin
      c8_s[i] = lzc8(src_s[i*LANE_W +: LANE_W]);
    end
  end

  // A lane pair continues into its low lane only when the high lane is all zero
  // (count 8, the only value with bit 3 set).
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      if (c8_s[2*j+1][3]) begin
        c16_s[j] = {1'b0, c8_s[2*j+1]} + {1'b0, c8_s[2*j]};
      end else begin
        c16_s[j] = {1'b0, c8_s[2*j+1]};
      end
    end
  end

  // Same merge one level up: bit 4 set means the upper half is all zero.
  always_comb begin
    if (c16_s[1][4]) begin
      c32_s = {1'b0, c16_s[1]} + {1'b0, c16_s[0]};
    end else begin
      c32_s = {1'b0, c16_s[1]};
    end
  end

  // Mode mux: replicate each element's count over its lanes.  A zero 32-bit
  // operand cannot be expressed as a 5-bit shift, so it is flagged via full_o
  // with a shift of 0 instead.
  always_comb begin
    shift_o = '0;
    lzc_o   = '0;
    full_o  = 1'b0;
    case (mode_i)
      PRECISION_CONFIG_16B: begin
        for (int i = 0; i < N_LANE; i++) begin
          lzc_o[i]   = {1'b0, c16_s[i>>1]};
          shift_o[i] = c16_s[i>>1];
        end
      end
      PRECISION_CONFIG_8B: begin
        for (int i = 0; i < N_LANE; i++) begin
          lzc_o[i]   = {2'b00, c8_s[i]};
          shift_o[i] = {1'b0, c8_s[i]};
        end
      end
      default: begin
        full_o = c32_s[5];
        for (int i = 0; i < N_LANE; i++) begin
          lzc_o[i]   = c32_s;
          shift_o[i] = c32_s[5] ? 5'd0 : c32_s[4:0];
        end
      end
    endcase
  end

endmodule

// File: rtl/lzc_norm_ctrl_decomposable.sv
// ---------------------------------------------------------------------------
// lzc_norm_ctrl_decomposable
// Two-stage pipelined normalisation control for the decomposable left
// shifter.  Stage 1 registers the operand, stage 2 registers the LZC result.
// Valid/ready on both sides, full throughput, up to two operands buffered
// under backpressure.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   in_valid/in_ready      - input handshake (in_ready is combinational)
//   in_data/in_mode/in_tag - operand, its precision mode and sideband tag
//   out_valid/out_ready    - output handshake
//   out_data               - operand, unmodified
//   out_shift/out_full     - shifter control
//   out_mode/out_tag       - mode and tag travelling with the operand
//   out_lzc                - per-lane count of the owning element
// ---------------------------------------------------------------------------
module lzc_norm_ctrl_decomposable
  import pe_pkg::*;
#(
  parameter bit COUNT_LEADING_ONES = 1'b0,
  parameter int TAG_W              = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [PRECISION_CONFIG_L-1:0]     in_mode,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [N_LANE-1:0][SHIFT_W-1:0]    out_shift,
  output logic                              out_full,
  output logic [PRECISION_CONFIG_L-1:0]     out_mode,
  output logic [N_LANE-1:0][LZC_W-1:0]      out_lzc,
  output logic [TAG_W-1:0]                  out_tag
);

  logic adv1_s, adv2_s;

  logic                          v1_q, v1_d;
  logic [DATA_W-1:0]             data1_q, data1_d;
  logic [PRECISION_CONFIG_L-1:0] mode1_q, mode1_d;
  logic [TAG_W-1:0]              tag1_q, tag1_d;

  logic                          v2_q, v2_d;
  logic [DATA_W-1:0]             data2_q, data2_d;
  logic [PRECISION_CONFIG_L-1:0] mode2_q, mode2_d;
  logic [TAG_W-1:0]              tag2_q, tag2_d;
  logic [N_LANE-1:0][SHIFT_W-1:0] shift2_q, shift2_d;
  logic                          full2_q, full2_d;
  logic [N_LANE-1:0][LZC_W-1:0]  lzc2_q, lzc2_d;

  logic [N_LANE-1:0][SHIFT_W-1:0] lzc_shift_s;
  logic                           lzc_full_s;
  logic [N_LANE-1:0][LZC_W-1:0]   lzc_cnt_s;

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv2_s   = !v2_q || out_ready;
  assign adv1_s   = !v1_q || adv2_s;
  assign in_ready = adv1_s;

  lzc_decomposable #(
    .COUNT_LEADING_ONES(COUNT_LEADING_ONES)
  ) u_lzc (
    .data_i (data1_q),
    .mode_i (mode1_q),
    .shift_o(lzc_shift_s),
    .full_o (lzc_full_s),
    .lzc_o  (lzc_cnt_s)
  );

  // Stage 1 next state: capture the operand on an input handshake.
  always_comb begin
    v1_d    = v1_q;
    data1_d = data1_q;
    mode1_d = mode1_q;
    tag1_d  = tag1_q;
    if (adv1_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        data1_d = in_data;
        mode1_d = in_mode;
        tag1_d  = in_tag;
      end else begin
        data1_d = data1_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2 next state: capture the LZC result when stage 1 hands over.
  always_comb begin
    v2_d     = v2_q;
    data2_d  = data2_q;
    mode2_d  = mode2_q;
    tag2_d   = tag2_q;
    shift2_d = shift2_q;
    full2_d  = full2_q;
    lzc2_d   = lzc2_q;
    if (adv2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        data2_d  = data1_q;
        mode2_d  = mode1_q;
        tag2_d   = tag1_q;
        shift2_d = lzc_shift_s;
        full2_d  = lzc_full_s;
        lzc2_d   = lzc_cnt_s;
      end else begin
        data2_d = data2_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers; reset drops any in-flight operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      data1_q  <= {DATA_W{1'b0}};
      mode1_q  <= PRECISION_CONFIG_32B;
      tag1_q   <= {TAG_W{1'b0}};
      v2_q     <= 1'b0;
      data2_q  <= {DATA_W{1'b0}};
      mode2_q  <= PRECISION_CONFIG_32B;
      tag2_q   <= {TAG_W{1'b0}};
      shift2_q <= '0;
      full2_q  <= 1'b0;
      lzc2_q   <= '0;
    end else begin
      v1_q     <= v1_d;
      data1_q  <= data1_d;
      mode1_q  <= mode1_d;
      tag1_q   <= tag1_d;
      v2_q     <= v2_d;
      data2_q  <= data2_d;
      mode2_q  <= mode2_d;
      tag2_q   <= tag2_d;
      shift2_q <= shift2_d;
      full2_q  <= full2_d;
      lzc2_q   <= lzc2_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = data2_q;
  assign out_mode  = mode2_q;
  assign out_tag   = tag2_q;
  assign out_shift = shift2_q;
  assign out_full  = full2_q;
  assign out_lzc   = lzc2_q;

endmodule

// File: tb/tb_lzc_norm_ctrl_decomposable.sv
module tb_lzc_norm_ctrl_decomposable;
  import pe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic [7:0]  in_tag;

  logic in_ready0, out_valid0, out_full0;
  logic [31:0] out_data0;
  logic [3:0][4:0] out_shift0;
  logic [1:0] out_mode0;
  logic [3:0][5:0] out_lzc0;
  logic [7:0] out_tag0;

  logic in_ready1, out_valid1, out_full1;
  logic [31:0] out_data1;
  logic [3:0][4:0] out_shift1;
  logic [1:0] out_mode1;
  logic [3:0][5:0] out_lzc1;
  logic [7:0] out_tag1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lzc_norm_ctrl_decomposable #(.COUNT_LEADING_ONES(1'b0), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_shift(out_shift0), .out_full(out_full0), .out_mode(out_mode0),
    .out_lzc(out_lzc0), .out_tag(out_tag0));

  lzc_norm_ctrl_decomposable #(.COUNT_LEADING_ONES(1'b1), .TAG_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_shift(out_shift1), .out_full(out_full1), .out_mode(out_mode1),
    .out_lzc(out_lzc1), .out_tag(out_tag1));

  typedef struct packed {
    logic [23:0] lzc;
    logic [19:0] shift;
    logic        full;
  } res_t;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  m;
    logic [7:0]  t;
  } op_t;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count = element width minus the bit length of the element value.
  function automatic int ref_cnt(input longint unsigned e, input int w);
    int n;
    n = 0;
    while (n < w && (e >> n) != 64'd0) n++;
    return w - n;
  endfunction

  function automatic res_t model(input logic [31:0] d, input logic [1:0] m, input bit clo);
    res_t r;
    int ew, k, c;
    longint unsigned e, mask;
    ew = (m == PRECISION_CONFIG_16B) ? 16 : (m == PRECISION_CONFIG_8B) ? 8 : 32;
    mask = (64'd1 << ew) - 64'd1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      k = (i * 8) / ew;
      e = ({32'd0, d} >> (k * ew)) & mask;
      if (clo) e = ~e & mask;
      c = ref_cnt(e, ew);
      r.lzc[i*6 +: 6] = c[5:0];
      r.shift[i*5 +: 5] = (ew == 32 && c == 32) ? 5'd0 : c[4:0];
      if (ew == 32 && c == 32) r.full = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_data();
    logic [31:0] d;
    logic [7:0] lane;
    d = $urandom;
    for (int i = 0; i < 4; i++) begin
      lane = d[i*8 +: 8];
      if ($urandom_range(0, 1) == 0) lane = lane >> $urandom_range(0, 8);
      d[i*8 +: 8] = lane;
    end
    if ($urandom_range(0, 1) == 0) d = d >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 0) d = ~d;
    if ($urandom_range(0, 9) == 0) d = 32'h0000_0000;
    if ($urandom_range(0, 9) == 0) d = 32'hFFFF_FFFF;
    return d;
  endfunction

  // One operand through an idle pipeline, checked against fixed expectations.
  task automatic directed(input string name, input logic [31:0] d, input logic [1:0] m,
                          input logic [7:0] t, input logic [23:0] el, input logic [19:0] es,
                          input logic ef, input bit use1);
    in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({name, "_valid"}, use1 ? out_valid1 : out_valid0, 1'b1);
    chk({name, "_lzc"},   use1 ? out_lzc1   : out_lzc0,   el);
    chk({name, "_shift"}, use1 ? out_shift1 : out_shift0, es);
    chk({name, "_full"},  use1 ? out_full1  : out_full0,  ef);
    chk({name, "_data"},  use1 ? out_data1  : out_data0,  d);
    chk({name, "_mode"},  use1 ? out_mode1  : out_mode0,  m);
    chk({name, "_tag"},   use1 ? out_tag1   : out_tag0,   t);
    step();
  endtask

  initial begin
    logic [31:0] bp_d [4];
    int sent, gotn, cycles;
    bit pending;
    op_t q[$];
    op_t cur, e;
    res_t r0, r1;

    // ---- reset values ----
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_mode = PRECISION_CONFIG_32B;
    in_tag = 8'd0; out_ready = 1'b0;
    step(); step();
    chk("rst_valid", out_valid0, 1'b0);
    chk("rst_data",  out_data0, 32'd0);
    chk("rst_shift", out_shift0, 20'd0);
    chk("rst_full",  out_full0, 1'b0);
    chk("rst_mode",  out_mode0, PRECISION_CONFIG_32B);
    chk("rst_lzc",   out_lzc0, 24'd0);
    chk("rst_tag",   out_tag0, 8'd0);
    rst = 1'b0;
    step();

    // ---- directed precision cases ----
    directed("b32_1234", 32'h0000_1234, PRECISION_CONFIG_32B, 8'h11,
             {6'd19, 6'd19, 6'd19, 6'd19}, {5'd19, 5'd19, 5'd19, 5'd19}, 1'b0, 1'b0);
    directed("b32_zero", 32'h0000_0000, PRECISION_CONFIG_32B, 8'h12,
             {6'd32, 6'd32, 6'd32, 6'd32}, 20'd0, 1'b1, 1'b0);
    directed("b16_18000", 32'h0001_8000, PRECISION_CONFIG_16B, 8'h13,
             {6'd15, 6'd15, 6'd0, 6'd0}, {5'd15, 5'd15, 5'd0, 5'd0}, 1'b0, 1'b0);
    directed("b16_00001", 32'h0000_0001, PRECISION_CONFIG_16B, 8'h14,
             {6'd16, 6'd16, 6'd15, 6'd15}, {5'd16, 5'd16, 5'd15, 5'd15}, 1'b0, 1'b0);
    directed("b8_110ff", 32'h0001_10FF, PRECISION_CONFIG_8B, 8'h15,
             {6'd8, 6'd7, 6'd3, 6'd0}, {5'd8, 5'd7, 5'd3, 5'd0}, 1'b0, 1'b0);
    directed("b3_asb32", 32'h0000_00FF, 2'd3, 8'h16,
             {6'd24, 6'd24, 6'd24, 6'd24}, {5'd24, 5'd24, 5'd24, 5'd24}, 1'b0, 1'b0);
    directed("clo_b32", 32'hFFFF_F000, PRECISION_CONFIG_32B, 8'h17,
             {6'd20, 6'd20, 6'd20, 6'd20}, {5'd20, 5'd20, 5'd20, 5'd20}, 1'b0, 1'b1);

    // ---- backpressure: 4 back-to-back operands, output stalled ----
    for (int k = 0; k < 4; k++) bp_d[k] = $urandom;
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (sent < 4); in_tag = 8'(sent + 1); in_data = bp_d[sent & 3];
      in_mode = PRECISION_CONFIG_32B;
      #1;
      if (c >= 2) begin
        chk("bp_in_ready_low", in_ready0, 1'b0);
        chk("bp_hold_valid", out_valid0, 1'b1);
        chk("bp_hold_tag", out_tag0, 8'd1);
        chk("bp_hold_data", out_data0, bp_d[0]);
      end
      if (in_valid && in_ready0) sent++;
      step();
    end
    chk("bp_accepts", sent, 2);
    out_ready = 1'b1;
    gotn = 0;
    for (int c = 0; c < 20 && gotn < 4; c++) begin
      in_valid = (sent < 4); in_tag = 8'(sent + 1); in_data = bp_d[sent & 3];
      #1;
      if (out_valid0) begin
        chk("bp_order_tag", out_tag0, gotn + 1);
        chk("bp_order_cycle", c, gotn);
        gotn++;
      end
      if (in_valid && in_ready0) sent++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_count", gotn, 4);
    step();

    // ---- reset with two operands in flight ----
    in_valid = 1'b1; in_data = 32'h0000_00F0; in_tag = 8'h21; in_mode = PRECISION_CONFIG_8B;
    step();
    in_data = 32'h0F00_0000; in_tag = 8'h22;
    step();
    in_valid = 1'b0;
    chk("mid_valid_before", out_valid0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid0, 1'b0);
    chk("mid_rst_tag", out_tag0, 8'd0);
    chk("mid_rst_data", out_data0, 32'd0);
    chk("mid_rst_lzc", out_lzc0, 24'd0);
    chk("mid_rst_mode", out_mode0, PRECISION_CONFIG_32B);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_8000; in_tag = 8'h23; in_mode = PRECISION_CONFIG_32B;
    step();
    in_valid = 1'b0;
    chk("post_rst_lat1", out_valid0, 1'b0);
    step();
    chk("post_rst_lat2", out_valid0, 1'b1);
    chk("post_rst_tag", out_tag0, 8'h23);
    chk("post_rst_lzc", out_lzc0, {6'd16, 6'd16, 6'd16, 6'd16});
    step();

    // ---- randomized traffic against the reference model ----
    sent = 0; gotn = 0; cycles = 0; pending = 1'b0;
    cur = '0;
    while (gotn < 300 && cycles < 5000) begin
      if (!pending && sent < 300 && $urandom_range(0, 3) != 0) begin
        cur.d = rand_data();
        cur.m = 2'($urandom_range(0, 3));
        cur.t = 8'(sent);
        pending = 1'b1;
      end
      in_valid = pending; in_data = cur.d; in_mode = cur.m; in_tag = cur.t;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid0 && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", out_valid0, 1'b0);
        end else begin
          e = q.pop_front();
          r0 = model(e.d, e.m, 1'b0);
          r1 = model(e.d, e.m, 1'b1);
          chk("rnd_data", out_data0, e.d);
          chk("rnd_mode", out_mode0, e.m);
          chk("rnd_tag", out_tag0, e.t);
          chk("rnd_lzc", out_lzc0, r0.lzc);
          chk("rnd_shift", out_shift0, r0.shift);
          chk("rnd_full", out_full0, r0.full);
          chk("rnd_clo_valid", out_valid1, 1'b1);
          chk("rnd_clo_lzc", out_lzc1, r1.lzc);
          chk("rnd_clo_shift", out_shift1, r1.shift);
          chk("rnd_clo_full", out_full1, r1.full);
          gotn++;
        end
      end
      if (in_valid && in_ready0) begin
        q.push_back(cur);
        sent++;
        pending = 1'b0;
      end
      step();
      cycles++;
    end
    chk("rnd_all_out", gotn, 300);
    chk("rnd_q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
